mem_arbiter: RTL and testbench

- Two-master arbiter/sequencer sharing the single CPU-side memory bus between instruction fetch (M0) and load/store (M1).
- Sits between the core's two memory ports and the address-decoding bus that splits RAM and UART traffic.
- Serialises accesses, drives one clean strobe per transfer, waits the fixed read latency, and returns registered read data with a one-cycle ack.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU-side memory bus: sequencer states, master ids, read mask.
// Pure definitions; no timing or flow control of its own.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam logic [3:0] WMASK_READ = 4'b0000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin or fixed-priority select; combinational grant, last_grant flop.
// Zero latency; grant is only recorded when gnt_en_i is high, so the caller can stall.
module rr_arbiter2 #(
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [1:0] req_i,
   input  logic       gnt_en_i,
   output logic       gnt_vld_o,
   output logic       gnt_id_o
);
   import mem_bus_pkg::*;

   logic last_grant;

   always_comb begin
      gnt_vld_o = |req_i;
      gnt_id_o  = M0;
      if (req_i == 2'b11)
         gnt_id_o = PRIO_FIXED ? M1 : ((last_grant == M0) ? M1 : M0);
      else if (req_i[1])
         gnt_id_o = M1;
   end

   // Reset to M1 so that M0 wins the very first tie.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         last_grant <= M1;
      else if (gnt_en_i && gnt_vld_o)
         last_grant <= gnt_id_o;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises M0/M1 onto one memory bus; write acks at T+1, read acks at T+2+RD_LATENCY.
// No backpressure from the bus; masters hold req until ack and are ignored while busy.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int RD_LATENCY = 1,
   parameter int PRIO_FIXED = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              m0_req_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [3:0]        m0_wmask_i,
   input  logic [31:0]       m0_wdata_i,
   output logic              m0_ack_o,
   output logic [31:0]       m0_rdata_o,
   input  logic              m1_req_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [3:0]        m1_wmask_i,
   input  logic [31:0]       m1_wdata_i,
   output logic              m1_ack_o,
   output logic [31:0]       m1_rdata_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic              bus_rstrb_o,
   output logic [3:0]        bus_wmask_o,
   output logic [31:0]       bus_wdata_o,
   input  logic [31:0]       bus_rdata_i,
   output logic              busy_o
);
   import mem_bus_pkg::*;

   localparam logic [3:0] LAT = 4'(RD_LATENCY);

   state_t            state;
   logic              gnt_id;
   logic [3:0]        cnt;
   logic              arb_vld;
   logic              arb_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [3:0]        sel_wmask;
   logic [31:0]       sel_wdata;

   rr_arbiter2 #(.PRIO_FIXED(PRIO_FIXED != 0)) u_arb (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .req_i     ({m1_req_i, m0_req_i}),
      .gnt_en_i  (state == IDLE),
      .gnt_vld_o (arb_vld),
      .gnt_id_o  (arb_id)
   );

   assign sel_addr  = (arb_id == M1) ? m1_addr_i  : m0_addr_i;
   assign sel_wmask = (arb_id == M1) ? m1_wmask_i : m0_wmask_i;
   assign sel_wdata = (arb_id == M1) ? m1_wdata_i : m0_wdata_i;
   assign busy_o    = (state != IDLE);

   // The bus_* registers double as the request latch: loaded on grant, cleared on return to IDLE.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         gnt_id      <= M0;
         cnt         <= '0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_wmask_o <= WMASK_READ;
         bus_rstrb_o <= 1'b0;
         m0_ack_o    <= 1'b0;
         m1_ack_o    <= 1'b0;
         m0_rdata_o  <= '0;
         m1_rdata_o  <= '0;
      end else begin
         bus_rstrb_o <= 1'b0;
         bus_wmask_o <= WMASK_READ;
         m0_ack_o    <= 1'b0;
         m1_ack_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_vld) begin
                  gnt_id      <= arb_id;
                  bus_addr_o  <= sel_addr;
                  bus_wdata_o <= sel_wdata;
                  bus_wmask_o <= sel_wmask;
                  bus_rstrb_o <= (sel_wmask == WMASK_READ);
                  // A write completes in the strobe cycle itself.
                  if (sel_wmask != WMASK_READ) begin
                     m0_ack_o <= (arb_id == M0);
                     m1_ack_o <= (arb_id == M1);
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus_wmask_o != WMASK_READ) begin
                  bus_addr_o  <= '0;
                  bus_wdata_o <= '0;
                  state       <= IDLE;
               end else begin
                  cnt   <= LAT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  if (gnt_id == M1) m1_rdata_o <= bus_rdata_i;
                  else              m0_rdata_o <= bus_rdata_i;
                  m0_ack_o <= (gnt_id == M0);
                  m1_ack_o <= (gnt_id == M1);
                  state    <= RESP;
               end
            end
            RESP: begin
               bus_addr_o  <= '0;
               bus_wdata_o <= '0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (L=1 RR, L=3 RR, L=2 fixed), directed cases
// then random masters, all checked every cycle against a transaction-timeline model.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req[3][2];
   logic [31:0] addr[3][2];
   logic [3:0]  wm[3][2];
   logic [31:0] wd[3][2];
   logic        ack[3][2];
   logic [31:0] rdo[3][2];
   logic [31:0] b_addr[3];
   logic [31:0] b_wdata[3];
   logic [31:0] b_rdata[3];
   logic [3:0]  b_wmask[3];
   logic        b_rstrb[3];
   logic        busy[3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_arbiter #(
         .ADDR_W     (32),
         .RD_LATENCY (g == 1 ? 3 : (g == 2 ? 2 : 1)),
         .PRIO_FIXED (g == 2 ? 1 : 0)
      ) u_dut (
         .clk_i       (clk),
         .rst_n_i     (rst_n),
         .m0_req_i    (req[g][0]),
         .m0_addr_i   (addr[g][0]),
         .m0_wmask_i  (wm[g][0]),
         .m0_wdata_i  (wd[g][0]),
         .m0_ack_o    (ack[g][0]),
         .m0_rdata_o  (rdo[g][0]),
         .m1_req_i    (req[g][1]),
         .m1_addr_i   (addr[g][1]),
         .m1_wmask_i  (wm[g][1]),
         .m1_wdata_i  (wd[g][1]),
         .m1_ack_o    (ack[g][1]),
         .m1_rdata_o  (rdo[g][1]),
         .bus_addr_o  (b_addr[g]),
         .bus_rstrb_o (b_rstrb[g]),
         .bus_wmask_o (b_wmask[g]),
         .bus_wdata_o (b_wdata[g]),
         .bus_rdata_i (b_rdata[g]),
         .busy_o      (busy[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 1) ? 3 : ((k == 2) ? 2 : 1);
   endfunction

   function automatic bit fixp_of(input int k);
      return (k == 2);
   endfunction

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction-level model: one outstanding transfer per instance, described by its
   // grant cycle and duration; outputs are a function of the offset from the grant.
   int          cyc = 0;
   bit          m_act[3];
   int          m_tg[3];
   int          m_dur[3];
   bit          m_win[3];
   bit          m_wr[3];
   bit          m_last[3];
   logic [31:0] m_a[3];
   logic [31:0] m_d[3];
   logic [3:0]  m_m[3];
   logic [31:0] m_rd[3][2];
   logic        ack_d[3][2];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      int          off;
      int          lat;
      bit          cw;
      bit          w;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic [31:0] a_wd;
      logic [3:0]  e_wm;
      logic        e_rs;
      logic        e_busy;
      logic [1:0]  e_ack;
      for (int k = 0; k < 3; k++) begin
         lat = lat_of(k);
         if (!rst_n) begin
            m_act[k] = 1'b0;
            m_last[k] = 1'b1;
            m_rd[k][0] = '0;
            m_rd[k][1] = '0;
         end else if (m_act[k] && cyc > m_tg[k] + m_dur[k]) begin
            m_act[k] = 1'b0;
         end
         off = cyc - m_tg[k];
         e_addr = '0; e_wd = '0; e_wm = '0; e_rs = 1'b0; e_busy = 1'b0; e_ack = '0; cw = 1'b1;
         if (m_act[k]) begin
            e_busy = 1'b1;
            e_addr = m_a[k];
            if (off == 1) begin
               e_wd = m_d[k];
               e_rs = !m_wr[k];
               e_wm = m_wr[k] ? m_m[k] : 4'h0;
            end else begin
               cw = 1'b0;
            end
            if (off == m_dur[k]) e_ack[m_win[k]] = 1'b1;
         end
         a_wd = cw ? b_wdata[k] : 32'h0;
         chk($sformatf("dut%0d cycle %0d outputs", k, cyc),
             {b_addr[k], a_wd, b_wmask[k], b_rstrb[k], busy[k], ack[k][1], ack[k][0], rdo[k][1], rdo[k][0]},
             {e_addr, e_wd, e_wm, e_rs, e_busy, e_ack, m_rd[k][1], m_rd[k][0]});
         if (m_act[k] && !m_wr[k] && off == 1 + lat) m_rd[k][m_win[k]] = b_rdata[k];
         ack_d[k][0] = rst_n ? ack[k][0] : 1'b0;
         ack_d[k][1] = rst_n ? ack[k][1] : 1'b0;
         if (rst_n && !m_act[k] && (req[k][0] || req[k][1])) begin
            if (req[k][0] && req[k][1]) w = fixp_of(k) ? 1'b1 : !m_last[k];
            else                        w = req[k][1];
            m_act[k]  = 1'b1;
            m_win[k]  = w;
            m_last[k] = w;
            m_tg[k]   = cyc;
            m_a[k]    = addr[k][w];
            m_d[k]    = wd[k][w];
            m_m[k]    = wm[k][w];
            m_wr[k]   = (wm[k][w] != 4'h0);
            m_dur[k]  = m_wr[k] ? 1 : 2 + lat;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_step();
      for (int k = 0; k < 3; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (req[k][p]) begin
               if (ack_d[k][p]) begin
                  req[k][p] = 1'b0;
               end else if ($urandom_range(0, 7) == 0) begin
                  addr[k][p] = $urandom;
                  wd[k][p]   = $urandom;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               req[k][p]  = 1'b1;
               addr[k][p] = $urandom;
               wd[k][p]   = $urandom;
               wm[k][p]   = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
         end
         b_rdata[k] = $urandom;
      end
   endtask

   initial begin
      int n, n1, early0, late0, got, acks;
      for (int k = 0; k < 3; k++) begin
         b_rdata[k] = '0;
         for (int p = 0; p < 2; p++) begin
            req[k][p] = 1'b0; addr[k][p] = '0; wm[k][p] = '0; wd[k][p] = '0;
         end
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset busy", busy[0], 0);
      chk("reset acks", {ack[0][1], ack[0][0]}, 0);
      chk("reset rdata", {rdo[0][1], rdo[0][0]}, 0);
      chk("reset bus", {b_addr[0], b_wdata[0], b_wmask[0], b_rstrb[0]}, 0);
      tick(); rst_n = 1'b1;
      @(negedge clk);

      // M0 read of 0x10 on the default instance
      tick(); req[0][0] = 1'b1; addr[0][0] = 32'h10; wm[0][0] = 4'h0; b_rdata[0] = 32'h0BADF00D;
      @(negedge clk); chk("d1 idle before grant", busy[0], 0);
      tick();
      @(negedge clk); chk("d1 strobe T+1", b_rstrb[0], 1); chk("d1 addr T+1", b_addr[0], 32'h10);
      tick(); b_rdata[0] = 32'hDEADBEEF;
      @(negedge clk); chk("d1 strobe T+2", b_rstrb[0], 0); chk("d1 ack early", ack[0][0], 0);
      tick(); b_rdata[0] = 32'h0BADF00D;
      @(negedge clk);
      chk("d1 m0 ack T+3", ack[0][0], 1);
      chk("d1 m0 rdata", rdo[0][0], 32'hDEADBEEF);
      chk("d1 m1 ack", ack[0][1], 0);
      tick(); req[0][0] = 1'b0;
      @(negedge clk); chk("d1 ack one cycle", ack[0][0], 0);

      // M1 byte write
      tick(); req[0][1] = 1'b1; addr[0][1] = 32'h0040_0000; wm[0][1] = 4'b0001; wd[0][1] = 32'h41;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("d2 wmask T+1", b_wmask[0], 4'b0001);
      chk("d2 m1 ack T+1", ack[0][1], 1);
      chk("d2 strobe", b_rstrb[0], 0);
      chk("d2 wdata", b_wdata[0], 32'h41);
      tick(); req[0][1] = 1'b0;
      @(negedge clk); chk("d2 wmask T+2", b_wmask[0], 0); chk("d2 ack T+2", ack[0][1], 0);

      // Both masters reading continuously, round-robin
      tick();
      req[0][0] = 1'b1; addr[0][0] = 32'h100; wm[0][0] = 4'h0;
      req[0][1] = 1'b1; addr[0][1] = 32'h200; wm[0][1] = 4'h0;
      @(negedge clk);
      n = 0;
      for (int c = 0; c < 80 && n < 6; c++) begin
         tick(); b_rdata[0] = b_addr[0] ^ 32'hA5A5_0000;
         @(negedge clk);
         if (ack[0][0] || ack[0][1]) begin
            chk("d3 single ack", ack[0][0] & ack[0][1], 0);
            chk($sformatf("d3 grant %0d id", n), ack[0][1], n % 2);
            chk($sformatf("d3 grant %0d rdata", n), rdo[0][n % 2],
                (n % 2 == 1) ? 32'hA5A5_0200 : 32'hA5A5_0100);
            n++;
         end
      end
      chk("d3 transfers", n, 6);
      tick(); req[0][0] = 1'b0; req[0][1] = 1'b0;

      // Fixed priority instance: M1 starves M0 until it drops
      req[2][0] = 1'b1; addr[2][0] = 32'h500; wm[2][0] = 4'h0;
      req[2][1] = 1'b1; addr[2][1] = 32'h600; wm[2][1] = 4'h0;
      b_rdata[2] = 32'h22;
      @(negedge clk);
      n1 = 0; early0 = 0; late0 = 0;
      for (int c = 0; c < 100 && late0 == 0; c++) begin
         tick(); if (n1 >= 4) req[2][1] = 1'b0;
         @(negedge clk);
         if (ack[2][1]) n1++;
         if (ack[2][0]) begin
            if (n1 < 4) early0++;
            else        late0++;
         end
      end
      chk("d4 m1 acks", n1, 4);
      chk("d4 m0 early acks", early0, 0);
      chk("d4 m0 acks after drop", late0, 1);
      tick(); req[2][0] = 1'b0; req[2][1] = 1'b0;

      // RD_LATENCY=3 read with cycle-tagged bus data
      req[1][0] = 1'b1; addr[1][0] = 32'h300; wm[1][0] = 4'h0; b_rdata[1] = 32'h1000;
      @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
         tick(); b_rdata[1] = 32'h1000 + 32'(k); if (k == 6) req[1][0] = 1'b0;
         @(negedge clk);
         if (k == 1) chk("d5 strobe T+1", b_rstrb[1], 1);
         if (k >= 2 && k <= 5) chk($sformatf("d5 addr T+%0d", k), b_addr[1], 32'h300);
         chk($sformatf("d5 ack T+%0d", k), ack[1][0], (k == 5) ? 1 : 0);
         if (k == 5) chk("d5 rdata", rdo[1][0], 32'h1004);
      end

      // Reset pulse during WAIT on the latency-3 instance
      tick(); req[1][0] = 1'b1; addr[1][0] = 32'h340; wm[1][0] = 4'h0; b_rdata[1] = 32'h0;
      tick(); tick(); tick();
      #1 rst_n = 1'b0;
      #1;
      chk("d6 busy in reset", busy[1], 0);
      chk("d6 addr in reset", b_addr[1], 0);
      chk("d6 rdata in reset", rdo[1][0], 0);
      @(negedge clk);
      tick(); rst_n = 1'b1; req[1][0] = 1'b0;
      acks = 0;
      repeat (8) begin
         @(negedge clk);
         if (ack[1][0] || ack[1][1]) acks++;
      end
      chk("d6 no ack after reset", acks, 0);
      tick(); req[1][0] = 1'b1; addr[1][0] = 32'h380; b_rdata[1] = 32'h77;
      @(negedge clk);
      got = 0;
      for (int c = 1; c <= 10 && got == 0; c++) begin
         tick();
         @(negedge clk);
         if (ack[1][0]) begin
            got = c;
            chk("d6 fresh rdata", rdo[1][0], 32'h77);
         end
      end
      chk("d6 fresh ack latency", got, 5);
      tick(); req[1][0] = 1'b0;
      @(negedge clk);

      // Random masters on all instances
      repeat (3000) begin
         tick();
         rand_step();
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
